audio_mixer_n: RTL

- Parametrised, time-multiplexed N-channel signed audio mixer with per-channel gain, mute and saturating output.
- Sits between the sound sources (SID variants, TED square-wave voice, cassette monitor) and the top-level `sound` output.
- Replaces the fixed three-term mix-and-clamp at top level.
- Adds gain, clip reporting and overrun detection.

---
 rtl/audio_mixer_pkg.sv | 62 ++++++
 rtl/audio_mixer_sat.sv | 73 +++++++
 rtl/audio_mixer_n.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_pkg.sv
// -----------------------------------------------------------------------------
// audio_mixer_pkg
// Shared types and helpers for the audio_mixer_n block:
//   - state_t    : mixer FSM states (IDLE, MAC, SAT)
//   - DC_K       : pole shift of the optional DC blocker (y_prev >>> DC_K)
//   - clog2()    : ceiling log2 for parameter arithmetic
//   - sat_signed : clamps a 64-bit signed value to an out_w-bit signed range
//                  and flags whether clamping happened
// Optional feature macro used by this block: AUDIO_MIXER_DC_BLOCK_EN
// -----------------------------------------------------------------------------
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam int DC_K  = 10;
  localparam int WIDE_W = 64;

  typedef struct packed {
    logic [WIDE_W-1:0] value;
    logic              clip;
  } sat_t;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Clamp a signed value to the signed range of an out_w-bit number.
  function automatic sat_t sat_signed(input logic signed [WIDE_W-1:0] value,
                                      input int out_w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) begin
      r.value = hi;
      r.clip  = 1'b1;
    end else if (value < lo) begin
      r.value = lo;
      r.clip  = 1'b1;
    end else begin
      r.value = value;
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_mixer_sat.sv
// -----------------------------------------------------------------------------
// audio_mixer_sat
// Output stage of the mixer: saturates the accumulator to OUT_W bits.
// With AUDIO_MIXER_DC_BLOCK_EN defined, a first-order DC blocker
//   y = acc - x_prev + y_prev - (y_prev >>> DC_K)
// is applied ahead of the saturator; its state advances only when i_en is high.
// Ports:
//   i_clk, i_rst, i_en : clock / async high reset / state update (DC blocker only)
//   i_acc              : signed accumulator, ACC_W bits
//   o_sound            : saturated signed result, OUT_W bits
//   o_clip             : high when the result was clamped
// -----------------------------------------------------------------------------
module audio_mixer_sat
  import audio_mixer_pkg::*;
#(
  parameter int ACC_W = 25,
  parameter int OUT_W = 16
) (
`ifdef AUDIO_MIXER_DC_BLOCK_EN
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
`endif
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [OUT_W-1:0] o_sound,
  output logic                    o_clip
);

  logic signed [ACC_W-1:0]  w_pre;
  logic signed [WIDE_W-1:0] w_wide;
  sat_t                     w_sat;
  logic                     w_unused_hi;

`ifdef AUDIO_MIXER_DC_BLOCK_EN
  logic signed [ACC_W-1:0] r_x_prev;
  logic signed [ACC_W-1:0] r_y_prev;

  // DC blocker recurrence on the raw mix.
  always_comb begin
    w_pre = i_acc - r_x_prev + r_y_prev - (r_y_prev >>> DC_K);
  end

  // DC blocker history, advanced once per produced sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
    end else if (i_en) begin
      r_x_prev <= i_acc;
      r_y_prev <= w_pre;
    end else begin
      r_x_prev <= r_x_prev;
      r_y_prev <= r_y_prev;
    end
  end
`else
  // Mix feeds the saturator directly.
  always_comb begin
    w_pre = i_acc;
  end
`endif

  // Sign-extend to the helper width and clamp.
  always_comb begin
    w_wide      = {{(WIDE_W-ACC_W){w_pre[ACC_W-1]}}, w_pre};
    w_sat       = sat_signed(w_wide, OUT_W);
    o_sound     = w_sat.value[OUT_W-1:0];
    o_clip      = w_sat.clip;
    // Upper bits are a copy of the sign after clamping; kept only for lint.
    w_unused_hi = &w_sat.value[WIDE_W-1:OUT_W];
  end

endmodule

// File: rtl/audio_mixer_n.sv
// -----------------------------------------------------------------------------
// audio_mixer_n
// Time-multiplexed N-channel signed audio mixer with per-channel gain, mute,
// saturating output, sticky clip flag and sticky overrun flag.
// One multiply-accumulate per cycle: ce_in at cycle 0 -> sound_valid at NCH+2.
// Optional feature macro: AUDIO_MIXER_DC_BLOCK_EN (DC blocker before saturation).
// Ports:
//   CLK28       in  : system clock
//   RESET       in  : asynchronous active-high reset
//   ce_in       in  : sample strobe (snapshot inputs and start a mix)
//   ch_data     in  : NCH packed signed samples, channel k at [k*IN_W +: IN_W]
//   ch_gain     in  : NCH packed unsigned gains, channel k at [k*GAIN_W +: GAIN_W]
//   ch_mute     in  : per-channel mute (1 = contributes zero)
//   clip_clr    in  : clears sticky clip (a new clip in the same cycle wins)
//   sound       out : saturated signed mix
//   sound_valid out : one-cycle pulse when sound updates
//   busy        out : high while a mix is in progress
//   clip        out : sticky saturation flag
//   overrun     out : sticky flag, ce_in seen while busy; cleared by RESET only
// -----------------------------------------------------------------------------
module audio_mixer_n
  import audio_mixer_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int IN_W       = 18,
  parameter int GAIN_W     = 4,
  parameter int GAIN_SHIFT = 2,
  parameter int OUT_W      = 16
) (
  input  logic                     CLK28,
  input  logic                     RESET,
  input  logic                     ce_in,
  input  logic [NCH*IN_W-1:0]      ch_data,
  input  logic [NCH*GAIN_W-1:0]    ch_gain,
  input  logic [NCH-1:0]           ch_mute,
  input  logic                     clip_clr,
  output logic signed [OUT_W-1:0]  sound,
  output logic                     sound_valid,
  output logic                     busy,
  output logic                     clip,
  output logic                     overrun
);

  localparam int IDX_W  = clog2(NCH);
  localparam int ACC_W  = IN_W + GAIN_W + clog2(NCH) + 1;
  localparam int PROD_W = IN_W + GAIN_W + 1;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [NCH*IN_W-1:0]       r_data;
  logic [NCH*GAIN_W-1:0]     r_gain;
  logic [NCH-1:0]            r_mute;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [OUT_W-1:0]   r_sound;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_clip;
  logic                      r_overrun;

  logic signed [IN_W-1:0]    w_sample;
  logic signed [GAIN_W:0]    w_gain;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W-1:0]  w_shifted;
  logic signed [ACC_W-1:0]   w_term;
  logic                      w_last;
  logic                      w_in_sat;
  logic [OUT_W-1:0]          w_sat_sound;
  logic                      w_sat_clip;

  // Per-cycle product term for the channel selected by r_idx.
  always_comb begin
    w_sample  = $signed(r_data[r_idx*IN_W +: IN_W]);
    // Zero-extend the gain so it multiplies as a non-negative signed value.
    w_gain    = $signed({1'b0, r_gain[r_idx*GAIN_W +: GAIN_W]});
    w_prod    = w_sample * w_gain;
    // Shift each product on its own (floor rounding), before accumulation.
    w_shifted = w_prod >>> GAIN_SHIFT;
    if (r_mute[r_idx]) begin
      w_term = '0;
    end else begin
      w_term = {{(ACC_W-PROD_W){w_shifted[PROD_W-1]}}, w_shifted};
    end
    w_last   = (r_idx == IDX_W'(NCH - 1));
    w_in_sat = (r_state == SAT);
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (ce_in) begin
          w_next_state = MAC;
        end else begin
          w_next_state = IDLE;
        end
      end
      MAC: begin
        if (w_last) begin
          w_next_state = SAT;
        end else begin
          w_next_state = MAC;
        end
      end
      SAT:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Snapshot, accumulate and output registers.
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      r_data  <= '0;
      r_gain  <= '0;
      r_mute  <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_sound <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ce_in) begin
            r_data <= ch_data;
            r_gain <= ch_gain;
            r_mute <= ch_mute;
            r_idx  <= '0;
            r_acc  <= '0;
            r_busy <= 1'b1;
          end
        end
        MAC: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + 1'b1;
        end
        SAT: begin
          r_sound <= $signed(w_sat_sound);
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Sticky clip: a clip in SAT beats a simultaneous clear.
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      r_clip <= 1'b0;
    end else begin
      r_clip <= (w_in_sat & w_sat_clip) | (r_clip & ~clip_clr);
    end
  end

  // Sticky overrun: strobe seen while MAC or SAT (including the SAT->IDLE cycle).
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun | (ce_in & (r_state != IDLE));
    end
  end

  audio_mixer_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    .i_clk   (CLK28),
    .i_rst   (RESET),
    .i_en    (w_in_sat),
`endif
    .i_acc   (r_acc),
    .o_sound (w_sat_sound),
    .o_clip  (w_sat_clip)
  );

  assign sound       = r_sound;
  assign sound_valid = r_valid;
  assign busy        = r_busy;
  assign clip        = r_clip;
  assign overrun     = r_overrun;

endmodule
